// File: rtl/cplxdiv_pkg.sv
// Shared types and helpers for the complex-division scheduler.
// Helpers work on a 64-bit container; callers cast back to their own width.
package cplxdiv_pkg;

    localparam int unsigned DW_DEF = 32;
    localparam int unsigned RW_DEF = 16;

    typedef enum logic [2:0] {
        StIdle,
        StIssueRe,
        StWaitbRe,
        StWaitdRe,
        StIssueIm,
        StWaitbIm,
        StWaitdIm,
        StFinish
    } state_t;

    // Two's-complement negate when en is set; the low bits stay correct after truncation.
    function automatic logic [63:0] cneg(input logic [63:0] x, input logic en);
        return en ? (~x + 64'd1) : x;
    endfunction

    // Magnitude of a signed value whose sign bit sits at position msb.
    function automatic logic [63:0] mag(input logic [63:0] x, input logic [5:0] msb);
        return cneg(x, x[msb]);
    endfunction

endpackage

// File: rtl/cplxdiv_sgnmag.sv
// Combinational conditional negate, used to apply the numerator sign to results.
// Driving neg with the operand's own sign bit yields the absolute value.
module cplxdiv_sgnmag
    import cplxdiv_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] din,
    input  logic         neg,
    output logic [W-1:0] dout
);

    always_comb begin
        dout = W'(cneg(64'(din), neg));
    end

endmodule

// File: rtl/cplxdiv_sched.sv
// Time-shares one sequential unsigned divider to produce the signed real and
// imaginary quotients/remainders of a complex division with a shared denominator.
module cplxdiv_sched
    import cplxdiv_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned RW = RW_DEF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] num_re,
    input  logic [DW-1:0] num_im,
    input  logic [RW-1:0] den,
    output logic          busy,
    output logic          done,
    output logic          dbz,
    output logic [DW-1:0] q_re,
    output logic [DW-1:0] q_im,
    output logic [RW:0]   r_re,
    output logic [RW:0]   r_im,
    output logic          div_run,
    input  logic          div_busy,
    output logic [DW-1:0] div_dividend,
    output logic [RW-1:0] div_divisor,
    input  logic [DW-1:0] div_quotient,
    input  logic [RW-1:0] div_rest
);

    state_t        state_q, state_d;
    logic [DW-1:0] nim_q;
    logic          sre_q;
    logic          dbz_q;
    logic [DW-1:0] qre_raw, qim_raw;
    logic [RW-1:0] rre_raw, rim_raw;
    logic [DW-1:0] q_re_s, q_im_s;
    logic [RW:0]   r_re_s, r_im_s;
    logic          accept;

    assign accept = (state_q == StIdle) && start;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; div_busy is only looked at in the WAIT states, so a
    // stale busy during ISSUE cannot cause an early capture.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (den == '0) ? StFinish : StIssueRe;
                end
            end
            StIssueRe: state_d = StWaitbRe;
            StWaitbRe: if (div_busy) state_d = StWaitdRe;
            StWaitdRe: if (!div_busy) state_d = StIssueIm;
            StIssueIm: state_d = StWaitbIm;
            StWaitbIm: if (div_busy) state_d = StWaitdIm;
            StWaitdIm: if (!div_busy) state_d = StFinish;
            StFinish:  state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy    = (state_q != StIdle);
        div_run = (state_q == StIssueRe) || (state_q == StIssueIm);
    end

    cplxdiv_sgnmag #(.W(DW)) u_q_re (.din(qre_raw), .neg(sre_q), .dout(q_re_s));
    cplxdiv_sgnmag #(.W(DW)) u_q_im (.din(qim_raw), .neg(nim_q[DW-1]), .dout(q_im_s));
    cplxdiv_sgnmag #(.W(RW+1)) u_r_re (
        .din  ({1'b0, rre_raw}),
        .neg  (sre_q),
        .dout (r_re_s)
    );
    cplxdiv_sgnmag #(.W(RW+1)) u_r_im (
        .din  ({1'b0, rim_raw}),
        .neg  (nim_q[DW-1]),
        .dout (r_im_s)
    );

    // Operand, capture and result registers. Divider operands are loaded one
    // cycle ahead of ISSUE so they are stable for the whole division.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            nim_q        <= '0;
            sre_q        <= 1'b0;
            dbz_q        <= 1'b0;
            qre_raw      <= '0;
            qim_raw      <= '0;
            rre_raw      <= '0;
            rim_raw      <= '0;
            div_dividend <= '0;
            div_divisor  <= '0;
            done         <= 1'b0;
            dbz          <= 1'b0;
            q_re         <= '0;
            q_im         <= '0;
            r_re         <= '0;
            r_im         <= '0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        nim_q <= num_im;
                        sre_q <= num_re[DW-1];
                        dbz_q <= (den == '0);
                        if (den != '0) begin
                            div_dividend <= DW'(mag(64'(num_re), 6'(DW - 1)));
                            div_divisor  <= den;
                        end
                    end
                end
                StWaitdRe: begin
                    if (!div_busy) begin
                        qre_raw      <= div_quotient;
                        rre_raw      <= div_rest;
                        div_dividend <= DW'(mag(64'(nim_q), 6'(DW - 1)));
                    end
                end
                StWaitdIm: begin
                    if (!div_busy) begin
                        qim_raw <= div_quotient;
                        rim_raw <= div_rest;
                    end
                end
                StFinish: begin
                    done <= 1'b1;
                    dbz  <= dbz_q;
                    q_re <= dbz_q ? '0 : q_re_s;
                    q_im <= dbz_q ? '0 : q_im_s;
                    r_re <= dbz_q ? '0 : r_re_s;
                    r_im <= dbz_q ? '0 : r_im_s;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cplxdiv_sched.sv
// Directed self-checking bench for cplxdiv_sched with a behavioural divider.
module tb_cplxdiv_sched;

    localparam int DIVLAT = 4;           // cycles the model divider holds busy
    localparam int TDIV   = DIVLAT + 2;  // div_run cycle through the cycle busy is sampled low
    localparam int LAT_OK = 2 * TDIV + 1;  // edges from accept edge+1 sample to done sample
    localparam int LAT_DBZ = 1;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] num_re = '0, num_im = '0;
    logic [15:0] den = '0;
    logic        busy, done, dbz, div_run;
    logic [31:0] q_re, q_im, div_dividend;
    logic [16:0] r_re, r_im;
    logic [15:0] div_divisor;
    logic        div_busy;
    logic [31:0] div_quotient;
    logic [15:0] div_rest;

    int total = 0;
    int bad   = 0;
    int runs  = 0;
    int cnt   = 0;
    int lat;
    int runs0;

    cplxdiv_sched u_dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .num_re       (num_re),
        .num_im       (num_im),
        .den          (den),
        .busy         (busy),
        .done         (done),
        .dbz          (dbz),
        .q_re         (q_re),
        .q_im         (q_im),
        .r_re         (r_re),
        .r_im         (r_im),
        .div_run      (div_run),
        .div_busy     (div_busy),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_quotient (div_quotient),
        .div_rest     (div_rest)
    );

    always #5 clock = ~clock;

    // Divider model: latches operands on run, busy for DIVLAT cycles.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            div_busy     <= 1'b0;
            cnt          <= 0;
            div_quotient <= '0;
            div_rest     <= '0;
        end else begin
            if (div_run) runs <= runs + 1;
            if (div_busy) begin
                if (cnt == 1) div_busy <= 1'b0;
                cnt <= cnt - 1;
            end else if (div_run) begin
                div_busy     <= 1'b1;
                cnt          <= DIVLAT;
                div_quotient <= div_dividend / {16'd0, div_divisor};
                div_rest     <= 16'(div_dividend % {16'd0, div_divisor});
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [15:0] d,
                          output int n);
        num_re = a;
        num_im = b;
        den    = d;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        chk("busy_after_accept", 64'(busy), 64'(1));
        wait_done(n);
    endtask

    initial begin
        #1 reset = 1'b1;
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_dbz", 64'(dbz), 64'(0));
        chk("rst_q_re", 64'(q_re), 64'(0));
        chk("rst_r_im", 64'(r_im), 64'(0));
        chk("rst_div_run", 64'(div_run), 64'(0));
        chk("rst_dividend", 64'(div_dividend), 64'(0));
        chk("rst_divisor", 64'(div_divisor), 64'(0));
        reset = 1'b0;
        tick();

        // 100 / 7 and -100 / 7, checking the first issue cycle too
        num_re = 32'd100;
        num_im = 32'hFFFF_FF9C;
        den    = 16'd7;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        chk("t1_run", 64'(div_run), 64'(1));
        chk("t1_dividend", 64'(div_dividend), 64'(100));
        chk("t1_divisor", 64'(div_divisor), 64'(7));
        tick();
        chk("t1_run_one_cycle", 64'(div_run), 64'(0));
        wait_done(lat);
        lat = lat + 1;
        chk("t1_latency", 64'(lat), 64'(LAT_OK));
        chk("t1_q_re", 64'(q_re), 64'(32'd14));
        chk("t1_r_re", 64'(r_re), 64'(17'd2));
        chk("t1_q_im", 64'(q_im), 64'(32'hFFFF_FFF2));
        chk("t1_r_im", 64'(r_im), 64'(17'h1_FFFE));
        chk("t1_dbz", 64'(dbz), 64'(0));
        tick();
        chk("t1_done_pulse", 64'(done), 64'(0));
        chk("t1_q_hold", 64'(q_re), 64'(32'd14));

        // Most negative numerator
        run_op(32'h8000_0000, 32'd0, 16'd1, lat);
        chk("t2_latency", 64'(lat), 64'(LAT_OK));
        chk("t2_q_re", 64'(q_re), 64'(32'h8000_0000));
        chk("t2_r_re", 64'(r_re), 64'(0));
        chk("t2_q_im", 64'(q_im), 64'(0));
        chk("t2_r_im", 64'(r_im), 64'(0));
        tick();

        // Divide by zero: fast path, divider never started
        runs0 = runs;
        run_op(32'd55, 32'hFFFF_FFFF, 16'd0, lat);
        chk("t3_latency", 64'(lat), 64'(LAT_DBZ));
        chk("t3_dbz", 64'(dbz), 64'(1));
        chk("t3_q_re", 64'(q_re), 64'(0));
        chk("t3_q_im", 64'(q_im), 64'(0));
        chk("t3_r_re", 64'(r_re), 64'(0));
        chk("t3_r_im", 64'(r_im), 64'(0));
        chk("t3_no_runs", 64'(runs), 64'(runs0));
        tick();

        // Numerator just below the denominator
        run_op(32'd65534, 32'hFFFF_0002, 16'd65535, lat);
        chk("t4_dbz_clear", 64'(dbz), 64'(0));
        chk("t4_q_re", 64'(q_re), 64'(0));
        chk("t4_q_im", 64'(q_im), 64'(0));
        chk("t4_r_re", 64'(r_re), 64'(17'd65534));
        chk("t4_r_im", 64'(r_im), 64'(17'h1_0002));
        tick();

        // Start while busy is ignored
        num_re = 32'd1000;
        num_im = 32'hFFFF_FFFD;
        den    = 16'd10;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        tick();
        tick();
        num_re = 32'd7;
        num_im = 32'd7;
        den    = 16'd7;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        wait_done(lat);
        chk("t5_q_re", 64'(q_re), 64'(32'd100));
        chk("t5_r_re", 64'(r_re), 64'(0));
        chk("t5_q_im", 64'(q_im), 64'(0));
        chk("t5_r_im", 64'(r_im), 64'(17'h1_FFFD));
        tick();
        chk("t5_idle_after_done", 64'(busy), 64'(0));
        // Start in the cycle after done is accepted
        run_op(32'd50, 32'd51, 16'd5, lat);
        chk("t5b_latency", 64'(lat), 64'(LAT_OK));
        chk("t5b_q_re", 64'(q_re), 64'(32'd10));
        chk("t5b_r_im", 64'(r_im), 64'(17'd1));
        tick();

        // Asynchronous reset during WAITD_RE
        num_re = 32'd1000;
        num_im = 32'd1000;
        den    = 16'd3;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        tick();
        tick();
        chk("t6_in_waitd", 64'(div_busy), 64'(1));
        #2 reset = 1'b1;
        #1;
        chk("t6_busy_async", 64'(busy), 64'(0));
        chk("t6_run_async", 64'(div_run), 64'(0));
        chk("t6_done_async", 64'(done), 64'(0));
        tick();
        reset = 1'b0;
        tick();
        run_op(32'd21, 32'hFFFF_FFEA, 16'd4, lat);
        chk("t6_latency", 64'(lat), 64'(LAT_OK));
        chk("t6_q_re", 64'(q_re), 64'(32'd5));
        chk("t6_r_re", 64'(r_re), 64'(17'd1));
        chk("t6_q_im", 64'(q_im), 64'(32'hFFFF_FFFB));
        chk("t6_r_im", 64'(r_im), 64'(17'h1_FFFE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
